// File: rtl/video_uart_pkg.sv
// Shared types and constants for the UART-driven video RAM loader.
package video_uart_pkg;

  // Loader FSM states; every byte-consuming state waits on rx_valid.
  typedef enum logic [3:0] {
    IDLE,
    ADDR_L,
    ADDR_H,
    CNT_L,
    CNT_H,
    COLOR,
    DATA_L,
    DATA_H,
    WRITE,
    DISCARD
  } state_e;

  localparam logic [7:0] CMD_FILL  = 8'h01;  // one attribute byte, then char bytes
  localparam logic [7:0] CMD_WORDS = 8'h02;  // full {attr,char} words, low byte first
  localparam logic [7:0] MODE_BASE = 8'h30;  // first mode-select byte
  localparam logic [7:0] MODE_LAST = 8'h36;  // last mode-select byte

  // Mode-select byte to video mode register value.
  function automatic logic [7:0] mode_decode(input logic [7:0] b);
    logic [7:0] m;
    m = 8'h00;
    case (b)
      MODE_BASE + 8'd0: m = 8'h00;
      MODE_BASE + 8'd1: m = 8'h01;
      MODE_BASE + 8'd2: m = 8'h02;
      MODE_BASE + 8'd3: m = 8'h03;
      MODE_BASE + 8'd4: m = 8'h07;
      MODE_BASE + 8'd5: m = 8'h0F;
      MODE_BASE + 8'd6: m = 8'h10;
      default:          m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uart_timeout.sv
// Inter-byte idle counter: counts cycles since the last clear and flags
// expire once CYCLES cycles have elapsed (holds there until cleared).
module uart_timeout #(
  parameter int CYCLES = 27000000
) (
  input  logic I_clk,
  input  logic rst_n,
  input  logic clear,
  output logic expire
);

  localparam int              W     = $clog2(CYCLES + 1);
  localparam logic [W-1:0]    LIMIT = W'(CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)              cnt_d = '0;
    else if (cnt_q != LIMIT) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge I_clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == LIMIT);

endmodule

// File: rtl/uart_vram_loader.sv
// Parses a byte stream from a UART receiver into video RAM writes and mode
// register updates, echoing every received byte back to the transmitter.
module uart_vram_loader
  import video_uart_pkg::*;
#(
  parameter int CLK_FRE    = 27,
  parameter int TIMEOUT_MS = 1000
) (
  input  logic        I_clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        vwe_n,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic [7:0]  mode,
  output logic        mode_we,
  output logic        busy
);

  localparam int TO_CYCLES = CLK_FRE * 1000 * TIMEOUT_MS;

  // Reset asserts immediately but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_sync_n;

  // Two-flop reset release synchroniser.
  always_ff @(posedge I_clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sync_n = rst_sync_q[1];

  state_e      state_q, state_d;
  logic [7:0]  type_q, type_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic        vwe_n_q, vwe_n_d;
  logic [7:0]  mode_q, mode_d;
  logic        mode_we_q, mode_we_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        to_clear, to_expire;

  // Idle time only matters mid-transaction; any byte restarts the window.
  assign to_clear = rx_valid || (state_q == IDLE);

  uart_timeout #(.CYCLES(TO_CYCLES)) u_timeout (
    .I_clk  (I_clk),
    .rst_n  (rst_sync_n),
    .clear  (to_clear),
    .expire (to_expire)
  );

  // Next-state and datapath decode for the loader FSM and echo path.
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    mode_d     = mode_q;
    mode_we_d  = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    // Echo: a new byte always overwrites, even during a tx handshake.
    if (rx_valid) begin
      tx_data_d  = rx_data;
      tx_valid_d = 1'b1;
    end else if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: if (rx_valid) begin
        if (rx_data < MODE_BASE) begin
          type_d  = rx_data;
          state_d = ADDR_L;
        end else if (rx_data <= MODE_LAST) begin
          mode_d    = mode_decode(rx_data);
          mode_we_d = 1'b1;
        end
      end
      ADDR_L: if (rx_valid) begin
        addr_d[7:0] = rx_data;
        state_d     = ADDR_H;
      end
      ADDR_H: if (rx_valid) begin
        addr_d[15:8] = rx_data;
        state_d      = CNT_L;
      end
      CNT_L: if (rx_valid) begin
        cnt_d[7:0] = rx_data;
        state_d    = CNT_H;
      end
      CNT_H: if (rx_valid) begin
        cnt_d[15:8] = rx_data;
        if (type_q == CMD_FILL)       state_d = COLOR;
        else if (type_q == CMD_WORDS) state_d = DATA_L;
        else                          state_d = DISCARD;
      end
      COLOR: if (rx_valid) begin
        data_d[15:8] = rx_data;
        state_d      = DATA_L;
      end
      // Fill mode reuses DATA_L for its char bytes: one byte per write.
      DATA_L: if (rx_valid) begin
        data_d[7:0] = rx_data;
        state_d     = (type_q == CMD_FILL) ? WRITE : DATA_H;
      end
      DATA_H: if (rx_valid) begin
        data_d[15:8] = rx_data;
        state_d      = WRITE;
      end
      // Strobe cycle; a byte landing here would be lost, but UART byte
      // spacing makes that impossible at any sane baud rate.
      WRITE: begin
        addr_d = addr_q + 16'd1;
        if (cnt_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q - 16'd1;
          state_d = DATA_L;
        end
      end
      DISCARD: ;
      default: state_d = IDLE;
    endcase

    // Idle timeout abandons the transaction; a byte in the same cycle wins.
    if (state_q != IDLE && to_expire && !rx_valid) state_d = IDLE;

    vwe_n_d = (state_d != WRITE);
  end

  // State and output registers.
  always_ff @(posedge I_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q    <= IDLE;
      type_q     <= 8'h00;
      addr_q     <= 16'h0000;
      cnt_q      <= 16'h0000;
      data_q     <= 16'h0000;
      vwe_n_q    <= 1'b1;
      mode_q     <= 8'h00;
      mode_we_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      vwe_n_q    <= vwe_n_d;
      mode_q     <= mode_d;
      mode_we_q  <= mode_we_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign vwe_n    = vwe_n_q;
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;
  assign mode     = mode_q;
  assign mode_we  = mode_we_q;
  assign busy     = (state_q != IDLE);

endmodule
